rename_map_table: RTL

- Parametrised register alias table for the out-of-order front end. Renames one decoded instruction per cycle.
- Maps architectural sources to physical tags and allocates a new physical tag for the destination from the free list.
- Returns the displaced tag for release at commit.
- Holds NUM_CKPT single-cycle snapshot slots with valid tracking, for branch recovery.

---
 rtl/rename_map_table_if.sv | 31 +++
 rtl/rename_map_table.sv | 127 ++++++++++++
 2 files changed

// File: rtl/rename_map_table_if.sv
// Rename-stage bundle between the decoder/free list and the register alias table.
// The master drives decoded instructions and the free-list head; the slave returns the renamed result.
interface rename_map_table_if #(
  parameter int AW     = 5,
  parameter int PHYS_W = 8
);
  logic              in_valid;
  logic              in_ready;
  logic [6:0]        opcode;
  logic [AW-1:0]     rs1;
  logic [AW-1:0]     rs2;
  logic [AW-1:0]     rd;
  logic              free_valid;
  logic [PHYS_W-1:0] free_tag;
  logic              free_pop;
  logic              out_valid;
  logic [PHYS_W-1:0] out_ps1;
  logic [PHYS_W-1:0] out_ps2;
  logic [PHYS_W-1:0] out_pd;
  logic [PHYS_W-1:0] out_old_pd;

  modport master (
    output in_valid, opcode, rs1, rs2, rd, free_valid, free_tag,
    input  in_ready, free_pop, out_valid, out_ps1, out_ps2, out_pd, out_old_pd
  );

  modport slave (
    input  in_valid, opcode, rs1, rs2, rd, free_valid, free_tag,
    output in_ready, free_pop, out_valid, out_ps1, out_ps2, out_pd, out_old_pd
  );
endinterface

// File: rtl/rename_map_table.sv
// Register alias table: renames one instruction per cycle, allocates destination tags from
// the free list and keeps NUM_CKPT snapshots of the map for branch recovery.
module rename_map_table #(
  parameter int                NUM_ARCH  = 32,
  parameter int                PHYS_W    = 8,
  parameter int                NUM_CKPT  = 8,
  parameter logic [PHYS_W-1:0] NOSRC_TAG = PHYS_W'(254),
  parameter logic [PHYS_W-1:0] NORD_TAG  = PHYS_W'(255),
  localparam int               AW        = $clog2(NUM_ARCH),
  localparam int               CW        = $clog2(NUM_CKPT)
) (
  input  logic                 clk,
  input  logic                 reset,
  rename_map_table_if.slave    rn,
  input  logic                 ckpt_save,
  input  logic [CW-1:0]        ckpt_save_id,
  input  logic                 ckpt_restore,
  input  logic [CW-1:0]        ckpt_restore_id,
  input  logic                 ckpt_release,
  input  logic [CW-1:0]        ckpt_release_id,
  output logic [NUM_CKPT-1:0]  ckpt_valid,
  output logic                 restore_err
);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  logic [PHYS_W-1:0]   map_q    [NUM_ARCH];
  logic [PHYS_W-1:0]   map_next [NUM_ARCH];
  logic [PHYS_W-1:0]   ckpt_mem [NUM_CKPT][NUM_ARCH];
  logic [NUM_CKPT-1:0] ckpt_valid_q;
  logic [NUM_CKPT-1:0] ckpt_valid_d;

  logic                needs_rd;
  logic                ready_d;
  logic                fire;
  logic                restore_ok;
  logic                save_en;
  logic [PHYS_W-1:0]   ps1_d;
  logic [PHYS_W-1:0]   ps2_d;

  logic                out_valid_q;
  logic [PHYS_W-1:0]   out_ps1_q;
  logic [PHYS_W-1:0]   out_ps2_q;
  logic [PHYS_W-1:0]   out_pd_q;
  logic [PHYS_W-1:0]   out_old_pd_q;
  logic                restore_err_q;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    needs_rd   = (rn.opcode != OP_BRANCH) && (rn.opcode != OP_STORE) && (rn.rd != '0);
    ready_d    = !ckpt_restore && (rn.free_valid || !needs_rd);
    fire       = rn.in_valid && ready_d;
    restore_ok = ckpt_restore && ckpt_valid_q[ckpt_restore_id];
    // A restore request of either outcome supersedes a concurrent save.
    save_en    = ckpt_save && !ckpt_restore;

    ps1_d = map_q[rn.rs1];
    ps2_d = map_q[rn.rs2];
    case (rn.opcode)
      OP_JALR, OP_LOAD, OP_IMM: ps2_d = NOSRC_TAG;
      OP_LUI, OP_AUIPC, OP_JAL: begin
        ps1_d = '0;
        ps2_d = NOSRC_TAG;
      end
      default: ;
    endcase

    // x0 is excluded by needs_rd, so entry 0 never changes.
    map_next = map_q;
    if (fire && needs_rd) map_next[rn.rd] = rn.free_tag;

    // Restore keeps only its own slot, then release clears, then save sets (save wins).
    ckpt_valid_d = ckpt_valid_q;
    if (restore_ok)   ckpt_valid_d = ckpt_valid_q & (NUM_CKPT'(1) << ckpt_restore_id);
    if (ckpt_release) ckpt_valid_d[ckpt_release_id] = 1'b0;
    if (save_en)      ckpt_valid_d[ckpt_save_id] = 1'b1;
  end

  // NOTE: sequential state is written with non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_ARCH; i++) map_q[i] <= PHYS_W'(i);
      ckpt_valid_q  <= '0;
      out_valid_q   <= 1'b0;
      out_ps1_q     <= '0;
      out_ps2_q     <= '0;
      out_pd_q      <= NORD_TAG;
      out_old_pd_q  <= NORD_TAG;
      restore_err_q <= 1'b0;
    end else begin
      if (restore_ok) map_q <= ckpt_mem[ckpt_restore_id];
      else            map_q <= map_next;
      ckpt_valid_q  <= ckpt_valid_d;
      out_valid_q   <= fire;
      restore_err_q <= ckpt_restore && !ckpt_valid_q[ckpt_restore_id];
      if (fire) begin
        out_ps1_q    <= ps1_d;
        out_ps2_q    <= ps2_d;
        out_pd_q     <= needs_rd ? rn.free_tag : NORD_TAG;
        out_old_pd_q <= needs_rd ? map_q[rn.rd] : NORD_TAG;
      end
    end
  end

  // NOTE: snapshot storage is deliberately not reset; ckpt_valid_q guards every read of it.
  always_ff @(posedge clk) begin
    if (save_en) ckpt_mem[ckpt_save_id] <= map_next;
  end

  assign rn.in_ready   = ready_d;
  assign rn.free_pop   = fire && needs_rd;
  assign rn.out_valid  = out_valid_q;
  assign rn.out_ps1    = out_ps1_q;
  assign rn.out_ps2    = out_ps2_q;
  assign rn.out_pd     = out_pd_q;
  assign rn.out_old_pd = out_old_pd_q;
  assign ckpt_valid    = ckpt_valid_q;
  assign restore_err   = restore_err_q;

endmodule
